crc_stream_ctrl: RTL

//   Sequencing stage that drives crc_engine. Accepts a stream of 32-bit words over valid/ready and

---
 rtl/crc_stream_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/crc_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : crc_stream_ctrl
// Brief    : Sequences a valid/ready word stream through an external CRC-32
//            engine and presents the final CRC through a valid/ready port.
//            Optional word counter is built when CRC_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module crc_stream_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [DATA_WIDTH-1:0] CRC_XOROUT = 32'hFFFFFFFF,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] eng_crc_in,
    output logic [DATA_WIDTH-1:0] eng_data_in,
    input  logic [DATA_WIDTH-1:0] eng_crc_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_crc,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_crc;
    logic [DATA_WIDTH-1:0] r_m_crc;
    logic                  r_m_valid;
    logic                  r_busy;
    logic                  w_accept;

    // start has priority over an incoming word, so the word is refused that cycle
    assign s_ready     = (r_state == S_RUN) && !start;
    assign w_accept    = s_valid && s_ready;
    assign eng_crc_in  = r_crc;
    assign eng_data_in = s_data;
    assign m_valid     = r_m_valid;
    assign m_crc       = r_m_crc;
    assign busy        = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_crc     <= CRC_INIT;
            r_m_crc   <= '0;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else if (start) begin
            r_state   <= S_RUN;
            r_crc     <= CRC_INIT;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_crc <= eng_crc_out;
                        if (s_last) begin
                            r_m_crc   <= eng_crc_out ^ CRC_XOROUT;
                            r_m_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CRC_CNT_EN
    generate
        if (1) begin : g_word_cnt
            logic [CNT_WIDTH-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst || start) begin
                    r_cnt <= '0;
                end else if (w_accept && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign word_count = r_cnt;
        end
    endgenerate
`else
    generate
        if (1) begin : g_no_word_cnt
            assign word_count = '0;
        end
    endgenerate
`endif

endmodule
`default_nettype wire
